// File: rtl/pinwheel_uart_loader.sv
// pinwheel_uart_loader: 8N1 serial receiver that packs bytes little-endian
// into 32-bit words and drives a RAM write port, for loading program images.
module pinwheel_uart_loader #(
  parameter int clock_rate = 24000000,
  parameter int baud_rate  = 1200,
  parameter int addr_width = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ser_rx,
  input  logic                  restart,
  output logic [addr_width-1:0] waddr,
  output logic [31:0]           wdata,
  output logic                  wren,
  output logic [7:0]            rx_byte,
  output logic                  rx_valid,
  output logic                  frame_err
);

  localparam int CPB = clock_rate / baud_rate;
  localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic                  sync1_q, sync2_q;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            rx_byte_q, rx_byte_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic [1:0]            lane_q, lane_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  wren_q, wren_d;
  logic [addr_width-1:0] waddr_q, waddr_d;

  logic rx_s;
  assign rx_s = sync2_q;

  // Receiver FSM: next state, bit timing, shift register and result pulses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          // A line that is high again at mid start bit was only a glitch.
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          // Returning to IDLE mid stop bit leaves room for a back-to-back start edge.
          state_d = S_IDLE;
          if (rx_s) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Word packer: lane placement, write strobe and address advance.
  always_comb begin
    lane_d  = lane_q;
    wdata_d = wdata_q;
    wren_d  = 1'b0;
    waddr_d = waddr_q;
    if (wren_q) waddr_d = waddr_q + addr_width'(1);
    if (restart) begin
      // Restart wins over any byte being packed this cycle.
      lane_d  = '0;
      waddr_d = '0;
    end else if (rx_valid_q) begin
      wdata_d[8*lane_q +: 8] = rx_byte_q;
      lane_d = lane_q + 2'd1;
      wren_d = (lane_q == 2'd3);
    end
  end

  // State registers; both synchronizer flops idle high like the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      lane_q      <= '0;
      wdata_q     <= '0;
      wren_q      <= 1'b0;
      waddr_q     <= '0;
    end else begin
      sync1_q     <= ser_rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      wren_q      <= wren_d;
      waddr_q     <= waddr_d;
    end
  end

  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign wren      = wren_q;
  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_pinwheel_uart_loader.sv
// Directed bench for pinwheel_uart_loader: 16 clocks per bit, 2-bit address.
module tb_pinwheel_uart_loader;
  localparam int CPB = 16;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ser_rx = 1'b1;
  logic          restart = 1'b0;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          wren;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          frame_err;

  int checks = 0;
  int failures = 0;

  logic [7:0]    q_bytes[$];
  logic [AW-1:0] q_waddr[$];
  logic [31:0]   q_wdata[$];
  int            ferr_cnt = 0;

  pinwheel_uart_loader #(.clock_rate(16), .baud_rate(1), .addr_width(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ser_rx(ser_rx), .restart(restart),
    .waddr(waddr), .wdata(wdata), .wren(wren), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Record output pulses on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) q_bytes.push_back(rx_byte);
      if (frame_err) ferr_cnt = ferr_cnt + 1;
      if (wren) begin
        q_waddr.push_back(waddr);
        q_wdata.push_back(wdata);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clear_logs();
    q_bytes.delete();
    q_waddr.delete();
    q_wdata.delete();
    ferr_cnt = 0;
  endtask

  task automatic idle(input int n);
    ser_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    ser_rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_words[5];
    exp_words[0] = 32'h04030201;
    exp_words[1] = 32'h08070605;
    exp_words[2] = 32'h0C0B0A09;
    exp_words[3] = 32'h100F0E0D;
    exp_words[4] = 32'h14131211;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_waddr", 32'(waddr), 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_wren", 32'(wren), 32'h0);
    check("rst_rx_byte", 32'(rx_byte), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    idle(5);

    // Four back-to-back bytes form one word at address 0
    clear_logs();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    idle(4);
    check("t1_nbytes", q_bytes.size(), 32'd4);
    if (q_bytes.size() == 4) begin
      check("t1_b0", 32'(q_bytes[0]), 32'h11);
      check("t1_b1", 32'(q_bytes[1]), 32'h22);
      check("t1_b2", 32'(q_bytes[2]), 32'h33);
      check("t1_b3", 32'(q_bytes[3]), 32'h44);
    end
    check("t1_nwren", q_waddr.size(), 32'd1);
    if (q_waddr.size() == 1) begin
      check("t1_waddr", 32'(q_waddr[0]), 32'h0);
      check("t1_wdata", q_wdata[0], 32'h44332211);
    end
    check("t1_waddr_after", 32'(waddr), 32'h1);
    check("t1_ferr", ferr_cnt, 32'd0);

    // Framing error drops the byte and leaves packing untouched
    pulse_restart();
    clear_logs();
    send_byte(8'hA5, 1'b0);
    idle(20);
    check("t2_ferr", ferr_cnt, 32'd1);
    check("t2_nobyte", q_bytes.size(), 32'd0);
    check("t2_rx_byte_held", 32'(rx_byte), 32'h44);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    idle(4);
    check("t2_nbytes", q_bytes.size(), 32'd4);
    if (q_bytes.size() == 4) check("t2_first", 32'(q_bytes[0]), 32'h01);
    check("t2_nwren", q_waddr.size(), 32'd1);
    if (q_waddr.size() == 1) begin
      check("t2_waddr", 32'(q_waddr[0]), 32'h0);
      check("t2_wdata", q_wdata[0], 32'h04030201);
    end

    // Short low glitch is rejected, then a normal byte follows
    clear_logs();
    ser_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(40);
    check("t3_nobyte", q_bytes.size(), 32'd0);
    check("t3_noferr", ferr_cnt, 32'd0);
    check("t3_nowren", q_waddr.size(), 32'd0);
    send_byte(8'h5A, 1'b1);
    idle(4);
    check("t3_nbytes", q_bytes.size(), 32'd1);
    if (q_bytes.size() == 1) check("t3_byte", 32'(q_bytes[0]), 32'h5A);

    // Five words with a 2-bit address wrap back to 0
    pulse_restart();
    clear_logs();
    for (int i = 0; i < 20; i++) send_byte(8'(i + 1), 1'b1);
    idle(4);
    check("t4_nwren", q_waddr.size(), 32'd5);
    if (q_waddr.size() == 5) begin
      for (int w = 0; w < 5; w++) begin
        check($sformatf("t4_waddr%0d", w), 32'(q_waddr[w]), 32'(w % 4));
        check($sformatf("t4_wdata%0d", w), q_wdata[w], exp_words[w]);
      end
    end

    // Restart discards a partial word
    clear_logs();
    send_byte(8'hFF, 1'b1);
    send_byte(8'hEE, 1'b1);
    idle(4);
    pulse_restart();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    idle(4);
    check("t5_nwren", q_waddr.size(), 32'd1);
    if (q_waddr.size() == 1) begin
      check("t5_waddr", 32'(q_waddr[0]), 32'h0);
      check("t5_wdata", q_wdata[0], 32'h04030201);
    end

    // Reset in the middle of a data bit clears every output at once
    clear_logs();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_waddr", 32'(waddr), 32'h0);
    check("t6_wdata", wdata, 32'h0);
    check("t6_wren", 32'(wren), 32'h0);
    check("t6_rx_byte", 32'(rx_byte), 32'h0);
    check("t6_rx_valid", 32'(rx_valid), 32'h0);
    check("t6_frame_err", 32'(frame_err), 32'h0);
    ser_rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);
    clear_logs();
    send_byte(8'h3C, 1'b1);
    idle(4);
    check("t6_nbytes", q_bytes.size(), 32'd1);
    if (q_bytes.size() == 1) check("t6_byte", 32'(q_bytes[0]), 32'h3C);
    check("t6_rx_byte_after", 32'(rx_byte), 32'h3C);
    check("t6_noferr", ferr_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
